// File: rtl/neuraedge_pe_pkg.sv
// Shared definitions for the NeuraEdge SIMD processing element and its array controller:
// derived widths, lane-vector types and accumulator saturation bounds.
package neuraedge_pe_pkg;

   localparam int DEF_LANES        = 4;
   localparam int DEF_DATA_WIDTH   = 8;
   localparam int DEF_WEIGHT_WIDTH = 8;
   localparam int DEF_ACCUM_WIDTH  = 32;

   localparam int PROD_W    = DEF_DATA_WIDTH + DEF_WEIGHT_WIDTH;
   localparam int MAX_ACC_W = 64;

   typedef logic [DEF_LANES-1:0][DEF_DATA_WIDTH-1:0]   act_vec_t;
   typedef logic [DEF_LANES-1:0][DEF_WEIGHT_WIDTH-1:0] weight_vec_t;
   typedef logic [DEF_LANES-1:0][PROD_W-1:0]           prod_vec_t;
   typedef logic [MAX_ACC_W-1:0]                       acc_word_t;

   // Largest representable accumulator value; callers keep the low acc_w bits.
   function automatic acc_word_t sat_max(input int acc_w, input logic is_signed);
      acc_word_t v;
      int        top;
      v   = '0;
      top = is_signed ? acc_w - 1 : acc_w;
      for (int i = 0; i < MAX_ACC_W; i++) begin
         if (i < top) begin
            v[i] = 1'b1;
         end
      end
      return v;
   endfunction

   // Smallest representable value, sign-extended across the full word when signed.
   function automatic acc_word_t sat_min(input int acc_w, input logic is_signed);
      acc_word_t v;
      v = '0;
      if (is_signed) begin
         for (int i = 0; i < MAX_ACC_W; i++) begin
            if (i >= acc_w - 1) begin
               v[i] = 1'b1;
            end
         end
      end
      return v;
   endfunction

endpackage

// File: rtl/neuraedge_pe_adder_tree.sv
// Combinational reduction of LANES products into one OUT_W sum; operands are sign- or
// zero-extended before the first level, unused leaves of the power-of-two tree are zero.
module neuraedge_pe_adder_tree
   import neuraedge_pe_pkg::*;
#(
   parameter int LANES = 4,
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
)(
   input  logic                   is_signed,
   input  logic [LANES*IN_W-1:0]  in_vec,
   output logic [OUT_W-1:0]       sum
);

   localparam int LEVELS = $clog2(LANES);
   localparam int N      = 1 << LEVELS;

   // Heap layout: node[1] is the root, node[N..2N-1] are the leaves.
   logic [OUT_W-1:0] node [1:2*N-1];

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_leaf
         if (gi < LANES) begin : g_used
            if (OUT_W > IN_W) begin : g_ext
               logic msb;
               assign msb = is_signed & in_vec[gi*IN_W + IN_W - 1];
               assign node[N+gi] = {{(OUT_W-IN_W){msb}}, in_vec[gi*IN_W +: IN_W]};
            end else begin : g_same
               assign node[N+gi] = in_vec[gi*IN_W +: OUT_W];
            end
         end else begin : g_pad
            assign node[N+gi] = '0;
         end
      end

      for (genvar gi = 1; gi < N; gi++) begin : g_node
         assign node[gi] = node[2*gi] + node[2*gi+1];
      end
   endgenerate

   assign sum = node[1];

endmodule

// File: rtl/neuraedge_simd_pe.sv
// LANES-wide integer dot-product PE: S1 registers lane products, S2 reduces and accumulates
// with saturation; packet results are held in a valid/ready output register.
module neuraedge_simd_pe
   import neuraedge_pe_pkg::*;
#(
   parameter int LANES        = 4,
   parameter int DATA_WIDTH   = 8,
   parameter int WEIGHT_WIDTH = 8,
   parameter int ACCUM_WIDTH  = 32
)(
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            cfg_signed,
   input  logic                            mac_clear,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [LANES*DATA_WIDTH-1:0]     in_data,
   input  logic [LANES*WEIGHT_WIDTH-1:0]   in_weight,
   input  logic                            in_last,
   output logic                            fwd_valid,
   output logic [LANES*DATA_WIDTH-1:0]     fwd_data,
   output logic [LANES*WEIGHT_WIDTH-1:0]   fwd_weight,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [ACCUM_WIDTH-1:0]          out_accum,
   output logic                            out_sat
);

   localparam int LANE_PROD_W = DATA_WIDTH + WEIGHT_WIDTH;
   localparam int MIN_ACC_W   = LANE_PROD_W + $clog2(LANES);

   localparam acc_word_t SMAX_W = sat_max(ACCUM_WIDTH, 1'b1);
   localparam acc_word_t SMIN_W = sat_min(ACCUM_WIDTH, 1'b1);
   localparam acc_word_t UMAX_W = sat_max(ACCUM_WIDTH, 1'b0);

   localparam logic [ACCUM_WIDTH-1:0] SMAX = SMAX_W[ACCUM_WIDTH-1:0];
   localparam logic [ACCUM_WIDTH-1:0] SMIN = SMIN_W[ACCUM_WIDTH-1:0];
   localparam logic [ACCUM_WIDTH-1:0] UMAX = UMAX_W[ACCUM_WIDTH-1:0];

   generate
      if (ACCUM_WIDTH < MIN_ACC_W) begin : g_bad_acc_w
         $error("neuraedge_simd_pe: ACCUM_WIDTH too small for one full beat");
      end
      if (ACCUM_WIDTH > MAX_ACC_W) begin : g_wide_acc_w
         $error("neuraedge_simd_pe: ACCUM_WIDTH exceeds package saturation word");
      end
   endgenerate

   logic                         en;
   logic                         accept;
   logic                         s2_fire;

   logic                         s1_valid_reg;
   logic                         s1_last_reg;
   logic                         s1_signed_reg;
   logic [LANES*LANE_PROD_W-1:0] s1_prod_reg;
   logic [LANES*LANE_PROD_W-1:0] prod_next;

   logic [ACCUM_WIDTH-1:0]       acc_reg;
   logic [ACCUM_WIDTH-1:0]       acc_next;
   logic                         sticky_reg;
   logic                         sticky_next;

   logic [ACCUM_WIDTH-1:0]       sum;
   logic [ACCUM_WIDTH:0]         wide;
   logic [ACCUM_WIDTH-1:0]       nxt;
   logic                         clamp;

   logic                         out_valid_reg;
   logic [ACCUM_WIDTH-1:0]       out_accum_reg;
   logic                         out_sat_reg;

   logic                         fwd_valid_reg;
   logic [LANES*DATA_WIDTH-1:0]  fwd_data_reg;
   logic [LANES*WEIGHT_WIDTH-1:0] fwd_weight_reg;

   // A pending, unconsumed result freezes both stages.
   assign en       = !out_valid_reg || out_ready;
   assign in_ready = rst_n && en && !mac_clear;
   assign accept   = in_valid && in_ready;
   assign s2_fire  = en && s1_valid_reg && !mac_clear;

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         logic                   a_msb;
         logic                   w_msb;
         logic [LANE_PROD_W-1:0] a_ext;
         logic [LANE_PROD_W-1:0] w_ext;
         assign a_msb = cfg_signed & in_data[gi*DATA_WIDTH + DATA_WIDTH - 1];
         assign w_msb = cfg_signed & in_weight[gi*WEIGHT_WIDTH + WEIGHT_WIDTH - 1];
         assign a_ext = {{WEIGHT_WIDTH{a_msb}}, in_data[gi*DATA_WIDTH +: DATA_WIDTH]};
         assign w_ext = {{DATA_WIDTH{w_msb}}, in_weight[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH]};
         // Truncated two's-complement product is exact in either mode at this width.
         assign prod_next[gi*LANE_PROD_W +: LANE_PROD_W] = a_ext * w_ext;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_reg  <= 1'b0;
         s1_last_reg   <= 1'b0;
         s1_signed_reg <= 1'b0;
         s1_prod_reg   <= '0;
      end else if (mac_clear) begin
         s1_valid_reg  <= 1'b0;
      end else if (en) begin
         s1_valid_reg <= accept;
         if (accept) begin
            s1_last_reg   <= in_last;
            s1_signed_reg <= cfg_signed;
            s1_prod_reg   <= prod_next;
         end
      end
   end

   neuraedge_pe_adder_tree #(
      .LANES (LANES),
      .IN_W  (LANE_PROD_W),
      .OUT_W (ACCUM_WIDTH)
   ) u_adder_tree (
      .is_signed (s1_signed_reg),
      .in_vec    (s1_prod_reg),
      .sum       (sum)
   );

   // One extra bit exposes signed overflow (top two bits differ) or unsigned carry-out.
   always_comb begin
      wide  = '0;
      nxt   = '0;
      clamp = 1'b0;
      if (s1_signed_reg) begin
         wide  = {acc_reg[ACCUM_WIDTH-1], acc_reg} + {sum[ACCUM_WIDTH-1], sum};
         clamp = wide[ACCUM_WIDTH] ^ wide[ACCUM_WIDTH-1];
         if (clamp) begin
            nxt = wide[ACCUM_WIDTH] ? SMIN : SMAX;
         end else begin
            nxt = wide[ACCUM_WIDTH-1:0];
         end
      end else begin
         wide  = {1'b0, acc_reg} + {1'b0, sum};
         clamp = wide[ACCUM_WIDTH];
         nxt   = clamp ? UMAX : wide[ACCUM_WIDTH-1:0];
      end
   end

   always_comb begin
      acc_next    = acc_reg;
      sticky_next = sticky_reg;
      if (mac_clear) begin
         acc_next    = '0;
         sticky_next = 1'b0;
      end else if (s2_fire) begin
         if (s1_last_reg) begin
            acc_next    = '0;
            sticky_next = 1'b0;
         end else begin
            acc_next    = nxt;
            sticky_next = sticky_reg | clamp;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_reg    <= '0;
         sticky_reg <= 1'b0;
      end else begin
         acc_reg    <= acc_next;
         sticky_reg <= sticky_next;
      end
   end

   // A new result may load in the same cycle the previous one is consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_reg <= 1'b0;
         out_accum_reg <= '0;
         out_sat_reg   <= 1'b0;
      end else if (s2_fire && s1_last_reg) begin
         out_valid_reg <= 1'b1;
         out_accum_reg <= nxt;
         out_sat_reg   <= sticky_reg | clamp;
      end else if (out_ready) begin
         out_valid_reg <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fwd_valid_reg  <= 1'b0;
         fwd_data_reg   <= '0;
         fwd_weight_reg <= '0;
      end else begin
         fwd_valid_reg <= accept;
         if (accept) begin
            fwd_data_reg   <= in_data;
            fwd_weight_reg <= in_weight;
         end
      end
   end

   assign fwd_valid  = fwd_valid_reg;
   assign fwd_data   = fwd_data_reg;
   assign fwd_weight = fwd_weight_reg;
   assign out_valid  = out_valid_reg;
   assign out_accum  = out_accum_reg;
   assign out_sat    = out_sat_reg;

endmodule

// File: tb/tb_neuraedge_simd_pe.sv
// Directed and randomized bench for neuraedge_simd_pe against a packet-level dot-product model.
module tb_neuraedge_simd_pe;

   localparam int LANES = 4;
   localparam int DW    = 8;
   localparam int WW    = 8;
   localparam int AW    = 20;
   localparam longint MASK = (longint'(1) << AW) - 1;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  cfg_signed;
   logic                  mac_clear;
   logic                  in_valid;
   logic                  in_ready;
   logic [LANES*DW-1:0]   in_data;
   logic [LANES*WW-1:0]   in_weight;
   logic                  in_last;
   logic                  fwd_valid;
   logic [LANES*DW-1:0]   fwd_data;
   logic [LANES*WW-1:0]   fwd_weight;
   logic                  out_valid;
   logic                  out_ready;
   logic [AW-1:0]         out_accum;
   logic                  out_sat;

   int checks = 0;
   int errors = 0;
   bit rand_ready = 0;

   // Reference model state
   longint acc_m;
   bit     sat_m;
   longint exp_acc_q[$];
   bit     exp_sat_q[$];

   always #5 clk = ~clk;

   neuraedge_simd_pe #(
      .LANES        (LANES),
      .DATA_WIDTH   (DW),
      .WEIGHT_WIDTH (WW),
      .ACCUM_WIDTH  (AW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_signed (cfg_signed),
      .mac_clear  (mac_clear),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_weight  (in_weight),
      .in_last    (in_last),
      .fwd_valid  (fwd_valid),
      .fwd_data   (fwd_data),
      .fwd_weight (fwd_weight),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_accum  (out_accum),
      .out_sat    (out_sat)
   );

   task automatic check(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint beat_sum(input logic [LANES*DW-1:0] d,
                                       input logic [LANES*WW-1:0] w, input bit sgn);
      longint s;
      s = 0;
      for (int i = 0; i < LANES; i++) begin
         if (sgn) s += longint'($signed(d[i*DW +: DW])) * longint'($signed(w[i*WW +: WW]));
         else     s += longint'(d[i*DW +: DW]) * longint'(w[i*WW +: WW]);
      end
      return s;
   endfunction

   function automatic longint clamp_val(input longint v, input bit sgn, output bit hit);
      longint hi;
      longint lo;
      hi  = sgn ? (longint'(1) << (AW-1)) - 1 : (longint'(1) << AW) - 1;
      lo  = sgn ? -(longint'(1) << (AW-1)) : 0;
      hit = (v > hi) || (v < lo);
      return (v > hi) ? hi : ((v < lo) ? lo : v);
   endfunction

   // Monitor: scoreboard, forwarding and hold checks, sampled on the falling edge.
   initial begin : monitor
      bit            fwd_pend;
      bit            stall_prev;
      logic [LANES*DW-1:0] fwd_d;
      logic [LANES*WW-1:0] fwd_w;
      logic [AW-1:0] held_acc;
      bit            hit;
      longint        ea;
      bit            es;
      fwd_pend   = 0;
      stall_prev = 0;
      fwd_d      = '0;
      fwd_w      = '0;
      held_acc   = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            acc_m = 0;
            sat_m = 0;
            exp_acc_q.delete();
            exp_sat_q.delete();
            fwd_pend   = 0;
            stall_prev = 0;
         end else begin
            check("fwd_valid", longint'(fwd_valid), longint'(fwd_pend));
            if (fwd_pend) begin
               check("fwd_data", longint'(fwd_data), longint'(fwd_d));
               check("fwd_weight", longint'(fwd_weight), longint'(fwd_w));
            end
            if (stall_prev) begin
               check("hold_valid", longint'(out_valid), 1);
               check("hold_accum", longint'(out_accum), longint'(held_acc));
            end
            if (out_valid && out_ready) begin
               if (exp_acc_q.size() == 0) begin
                  check("unexpected_result", 1, 0);
               end else begin
                  ea = exp_acc_q.pop_front();
                  es = exp_sat_q.pop_front();
                  check("sb_accum", longint'(out_accum), ea & MASK);
                  check("sb_sat", longint'(out_sat), longint'(es));
               end
            end
            stall_prev = out_valid && !out_ready;
            held_acc   = out_accum;
            if (mac_clear) begin
               acc_m = 0;
               sat_m = 0;
            end
            fwd_pend = in_valid && in_ready;
            if (in_valid && in_ready) begin
               fwd_d = in_data;
               fwd_w = in_weight;
               acc_m = clamp_val(acc_m + beat_sum(in_data, in_weight, cfg_signed), cfg_signed, hit);
               sat_m = sat_m | hit;
               if (in_last) begin
                  exp_acc_q.push_back(acc_m);
                  exp_sat_q.push_back(sat_m);
                  acc_m = 0;
                  sat_m = 0;
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic send_beat(input logic [LANES*DW-1:0] d, input logic [LANES*WW-1:0] w,
                            input bit last, input bit sgn);
      bit done;
      done       = 0;
      in_valid   = 1'b1;
      in_data    = d;
      in_weight  = w;
      in_last    = last;
      cfg_signed = sgn;
      for (int i = 0; i < 500 && !done; i++) begin
         @(negedge clk);
         done = in_ready;
         tick();
      end
      if (!done) check("send_timeout", 0, 1);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_out_valid(output bit seen);
      seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         seen = out_valid;
         if (!seen) tick();
      end
   endtask

   // Expects out_ready low; checks the held result, then consumes it.
   task automatic expect_result(input string tag, input longint exp_acc, input bit exp_sat);
      bit seen;
      wait_out_valid(seen);
      check({tag, "_valid"}, longint'(seen), 1);
      check({tag, "_accum"}, longint'(out_accum), exp_acc & MASK);
      check({tag, "_sat"}, longint'(out_sat), longint'(exp_sat));
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_in_ready"}, longint'(in_ready), 0);
      check({tag, "_fwd_valid"}, longint'(fwd_valid), 0);
      check({tag, "_fwd_data"}, longint'(fwd_data), 0);
      check({tag, "_fwd_weight"}, longint'(fwd_weight), 0);
      check({tag, "_out_valid"}, longint'(out_valid), 0);
      check({tag, "_out_accum"}, longint'(out_accum), 0);
      check({tag, "_out_sat"}, longint'(out_sat), 0);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      logic [LANES*DW-1:0] d;
      logic [LANES*WW-1:0] w;
      int  len;
      bit  sgn;
      bit  seen;

      rst_n      = 1'b0;
      cfg_signed = 1'b0;
      mac_clear  = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;
      in_weight  = '0;
      in_last    = 1'b0;
      out_ready  = 1'b0;
      #12;
      check_all_zero("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();

      // 1: single-beat signed packet, two-edge latency
      send_beat(32'h04030201, 32'h08070605, 1'b1, 1'b1);
      check("t1_lat_edge1", longint'(out_valid), 0);
      tick();
      check("t1_lat_edge2", longint'(out_valid), 1);
      expect_result("t1", 70, 1'b0);

      // 2: signed saturation, then a clean packet
      for (int b = 0; b < 8; b++) send_beat(32'h80808080, 32'h80808080, b == 7, 1'b1);
      expect_result("t2_sat", 524287, 1'b1);
      send_beat(32'h01010101, 32'h01010101, 1'b1, 1'b1);
      expect_result("t2_next", 4, 1'b0);

      // 3: all-ones operands, unsigned then signed
      for (int b = 0; b < 3; b++) send_beat(32'hFFFFFFFF, 32'hFFFFFFFF, b == 2, 1'b0);
      expect_result("t3_uns", 780300, 1'b0);
      for (int b = 0; b < 3; b++) send_beat(32'hFFFFFFFF, 32'hFFFFFFFF, b == 2, 1'b1);
      expect_result("t3_sgn", 12, 1'b0);

      // 4: back-pressure from a pending result
      send_beat(32'h04030201, 32'h08070605, 1'b1, 1'b1);
      wait_out_valid(seen);
      check("t4_pending", longint'(seen), 1);
      tick();
      in_valid   = 1'b1;
      in_data    = 32'h01010101;
      in_weight  = 32'h01010101;
      in_last    = 1'b1;
      cfg_signed = 1'b1;
      @(negedge clk);
      check("t4_in_ready_low", longint'(in_ready), 0);
      tick();
      @(negedge clk);
      check("t4_fwd_valid_low", longint'(fwd_valid), 0);
      check("t4_hold_accum", longint'(out_accum), 70);
      tick();
      out_ready = 1'b1;
      #1;
      check("t4_in_ready_same_cycle", longint'(in_ready), 1);
      tick();
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      expect_result("t4", 4, 1'b0);

      // 5: mac_clear mid-packet discards the partial sum
      send_beat(32'h0A0A0A0A, 32'h0A0A0A0A, 1'b0, 1'b1);
      send_beat(32'h0A0A0A0A, 32'h0A0A0A0A, 1'b0, 1'b1);
      mac_clear = 1'b1;
      tick();
      mac_clear = 1'b0;
      send_beat(32'h01010101, 32'h02020202, 1'b1, 1'b1);
      expect_result("t5", 8, 1'b0);

      // 6: asynchronous reset mid-packet
      out_ready = 1'b1;
      send_beat(32'h04030201, 32'h08070605, 1'b1, 1'b1);
      send_beat(32'h05050505, 32'h03030303, 1'b0, 1'b1);
      send_beat(32'h05050505, 32'h03030303, 1'b0, 1'b1);
      tick();
      tick();
      #1;
      rst_n = 1'b0;
      #1;
      check_all_zero("t6_reset");
      tick();
      tick();
      rst_n     = 1'b1;
      out_ready = 1'b0;
      send_beat(32'h01010101, 32'h01010101, 1'b1, 1'b1);
      expect_result("t6_after", 4, 1'b0);

      // Randomized packets with random output back-pressure and input gaps
      rand_ready = 1;
      for (int p = 0; p < 40; p++) begin
         len = $urandom_range(1, 8);
         sgn = $urandom_range(0, 1) != 0;
         for (int b = 0; b < len; b++) begin
            d = ($urandom_range(0, 2) == 0) ? {LANES{8'h80}} : LANES*DW'($urandom);
            w = ($urandom_range(0, 2) == 0) ? {LANES{8'h80}} : LANES*WW'($urandom);
            send_beat(d, w, b == len - 1, sgn);
            if ($urandom_range(0, 4) == 0) tick();
         end
      end
      rand_ready = 0;
      out_ready  = 1'b1;
      for (int i = 0; i < 200 && exp_acc_q.size() != 0; i++) tick();
      tick();
      check("drain_empty", longint'(exp_acc_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
